// File: rtl/ppu_pix_compositor.sv
// ppu_pix_compositor
// Resolves the visible pixel from the background and NUM_SPR prioritised
// sprite lanes, looks it up in a 32-entry mirrored palette RAM and emits a
// registered system palette index with greyscale and emphasis applied.
// It also owns the CPU palette port and the sprite-0 hit latch.
//
// Ports:
//   clk_in, rst_in          clock, async active-low reset
//   pix_pulse_in, nes_x_in  pixel strobe and x coordinate
//   frame_start_in          start-of-frame strobe (clears sprite-0 hit)
//   bg_en_in, spr_en_in     layer enables
//   bg_ls_clip_in, spr_ls_clip_in  hide layer in leftmost CLIP_W pixels
//   greyscale_in, emph_in   colour modifiers
//   bg_idx_in, spr_idx_in, spr_pri_in  layer palette indices / priorities
//   pram_a_in, pram_d_in, pram_wr_in, pram_d_out  CPU palette port
//   sys_idx_out, emph_out, pix_valid_out  pixel output (2-cycle latency)
//   spr0_hit_out            sprite-0 hit flag
module ppu_pix_compositor #(
  parameter int NUM_SPR = 8,
  parameter int COL_W   = 6,
  parameter int X_W     = 10,
  parameter int CLIP_W  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 pix_pulse_in,
  input  logic [X_W-1:0]       nes_x_in,
  input  logic                 frame_start_in,
  input  logic                 bg_en_in,
  input  logic                 spr_en_in,
  input  logic                 bg_ls_clip_in,
  input  logic                 spr_ls_clip_in,
  input  logic                 greyscale_in,
  input  logic [2:0]           emph_in,
  input  logic [3:0]           bg_idx_in,
  input  logic [4*NUM_SPR-1:0] spr_idx_in,
  input  logic [NUM_SPR-1:0]   spr_pri_in,
  input  logic [4:0]           pram_a_in,
  input  logic [COL_W-1:0]     pram_d_in,
  input  logic                 pram_wr_in,
  output logic [COL_W-1:0]     pram_d_out,
  output logic [COL_W-1:0]     sys_idx_out,
  output logic [2:0]           emph_out,
  output logic                 pix_valid_out,
  output logic                 spr0_hit_out
);

  localparam logic [COL_W-1:0] GREY_MASK = {2'b11, {(COL_W-2){1'b0}}};

  // Entries 0x10/0x14/0x18/0x1C alias the backdrop entries 0x00/0x04/0x08/0x0C.
  function automatic logic [4:0] mirror(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  logic [COL_W-1:0] pal [32];

  logic               in_clip;
  logic               bg_op;
  logic [NUM_SPR-1:0] spr_op;
  logic               win_found;
  logic [3:0]         win_idx;
  logic               win_pri;
  logic [4:0]         sel_addr;
  logic               hit_cond;

  logic               s1_valid;
  logic [4:0]         s1_addr;
  logic               s1_hit;
  logic               s1_grey;
  logic [2:0]         s1_emph;

  assign in_clip = nes_x_in < X_W'(CLIP_W);
  assign bg_op   = bg_en_in && !(bg_ls_clip_in && in_clip) && (bg_idx_in[1:0] != 2'b00);

  always_comb begin
    spr_op = '0;
    for (int k = 0; k < NUM_SPR; k++) begin
      spr_op[k] = spr_en_in && !(spr_ls_clip_in && in_clip) &&
                  (spr_idx_in[4*k +: 2] != 2'b00);
    end
  end

  // Lowest opaque lane wins regardless of its priority bit, so a "behind"
  // sprite still masks every higher-numbered lane.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'h0;
    win_pri   = 1'b0;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      if (spr_op[k]) begin
        win_found = 1'b1;
        win_idx   = spr_idx_in[4*k +: 4];
        win_pri   = spr_pri_in[k];
      end
    end
  end

  always_comb begin
    sel_addr = 5'h00;
    if (win_found && (!win_pri || !bg_op)) begin
      sel_addr = {1'b1, win_idx};
    end else if (bg_op) begin
      sel_addr = {1'b0, bg_idx_in};
    end
  end

  assign hit_cond = spr_op[0] && bg_op && (nes_x_in != X_W'(255));

  // Palette RAM and CPU read port. A write and a lookup on the same edge
  // see the old contents because both are non-blocking reads of pal.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        pal[i] <= '0;
      end
      pram_d_out <= '0;
    end else begin
      if (pram_wr_in) begin
        pal[mirror(pram_a_in)] <= pram_d_in;
      end
      pram_d_out <= pal[mirror(pram_a_in)];
    end
  end

  // Stage 1: resolved address and per-pixel attributes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_addr  <= 5'h00;
      s1_hit   <= 1'b0;
      s1_grey  <= 1'b0;
      s1_emph  <= 3'b000;
    end else begin
      s1_valid <= pix_pulse_in;
      if (pix_pulse_in) begin
        s1_addr <= sel_addr;
        s1_hit  <= hit_cond;
        s1_grey <= greyscale_in;
        s1_emph <= emph_in;
      end
    end
  end

  // Stage 2: palette lookup, output registers and sprite-0 latch.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sys_idx_out   <= '0;
      emph_out      <= 3'b000;
      pix_valid_out <= 1'b0;
      spr0_hit_out  <= 1'b0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        sys_idx_out <= s1_grey ? (pal[mirror(s1_addr)] & GREY_MASK) : pal[mirror(s1_addr)];
        emph_out    <= s1_emph;
      end
      // Frame start takes precedence, which also drops a hit waiting in S1.
      if (frame_start_in) begin
        spr0_hit_out <= 1'b0;
      end else if (s1_valid && s1_hit) begin
        spr0_hit_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_pix_compositor.sv
module tb_ppu_pix_compositor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        pix_pulse_in;
  logic [9:0]  nes_x_in;
  logic        frame_start_in;
  logic        bg_en_in, spr_en_in, bg_ls_clip_in, spr_ls_clip_in;
  logic        greyscale_in;
  logic [2:0]  emph_in;
  logic [3:0]  bg_idx_in;
  logic [31:0] spr_idx_in;
  logic [7:0]  spr_pri_in;
  logic [4:0]  pram_a_in;
  logic [5:0]  pram_d_in;
  logic        pram_wr_in;
  logic [5:0]  pram_d_out, sys_idx_out;
  logic [2:0]  emph_out;
  logic        pix_valid_out, spr0_hit_out;

  int checks = 0;
  int failures = 0;

  ppu_pix_compositor dut (
    .clk_in(clk_in), .rst_in(rst_in), .pix_pulse_in(pix_pulse_in), .nes_x_in(nes_x_in),
    .frame_start_in(frame_start_in), .bg_en_in(bg_en_in), .spr_en_in(spr_en_in),
    .bg_ls_clip_in(bg_ls_clip_in), .spr_ls_clip_in(spr_ls_clip_in),
    .greyscale_in(greyscale_in), .emph_in(emph_in), .bg_idx_in(bg_idx_in),
    .spr_idx_in(spr_idx_in), .spr_pri_in(spr_pri_in), .pram_a_in(pram_a_in),
    .pram_d_in(pram_d_in), .pram_wr_in(pram_wr_in), .pram_d_out(pram_d_out),
    .sys_idx_out(sys_idx_out), .emph_out(emph_out), .pix_valid_out(pix_valid_out),
    .spr0_hit_out(spr0_hit_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [5:0] d);
    pram_a_in = a; pram_d_in = d; pram_wr_in = 1'b1;
    tick();
    pram_wr_in = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [5:0] v);
    pram_a_in = a;
    tick();
    v = pram_d_out;
  endtask

  // One pulse; returns right after the edge where the pixel reaches the output.
  task automatic pix();
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (sys_idx_out !== 6'h00) begin failures++; $display("FAIL reset_sys got=%h exp=00", sys_idx_out); end
    checks++; if (emph_out !== 3'h0) begin failures++; $display("FAIL reset_emph got=%h exp=0", emph_out); end
    checks++; if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pix_valid_out); end
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", spr0_hit_out); end
    checks++; if (pram_d_out !== 6'h00) begin failures++; $display("FAIL reset_pram got=%h exp=00", pram_d_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_palette();
    logic [5:0] v;
    cpu_write(5'h10, 6'h2A);
    cpu_read(5'h00, v);
    checks++; if (v !== 6'h2A) begin failures++; $display("FAIL pal_mirror_10 got=%h exp=2a", v); end
    cpu_write(5'h11, 6'h15);
    cpu_read(5'h01, v);
    checks++; if (v !== 6'h00) begin failures++; $display("FAIL pal_no_mirror_01 got=%h exp=00", v); end
    cpu_read(5'h11, v);
    checks++; if (v !== 6'h15) begin failures++; $display("FAIL pal_read_11 got=%h exp=15", v); end
    cpu_write(5'h1C, 6'h0B);
    cpu_read(5'h0C, v);
    checks++; if (v !== 6'h0B) begin failures++; $display("FAIL pal_mirror_1c got=%h exp=0b", v); end
  endtask

  task automatic test_bg();
    cpu_write(5'h05, 6'h16);
    bg_idx_in = 4'h5; spr_idx_in = 32'h0; nes_x_in = 10'd100;
    pix();
    checks++; if (pix_valid_out !== 1'b1) begin failures++; $display("FAIL bg_valid got=%b exp=1", pix_valid_out); end
    checks++; if (sys_idx_out !== 6'h16) begin failures++; $display("FAIL bg_idx got=%h exp=16", sys_idx_out); end
    tick();
    checks++; if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL bg_valid_drop got=%b exp=0", pix_valid_out); end
    checks++; if (sys_idx_out !== 6'h16) begin failures++; $display("FAIL bg_hold got=%h exp=16", sys_idx_out); end
  endtask

  task automatic test_sprite();
    cpu_write(5'h11, 6'h30);
    cpu_write(5'h12, 6'h0F);
    cpu_write(5'h01, 6'h07);
    spr_idx_in = 32'h0020_0100; spr_pri_in = 8'h00; bg_idx_in = 4'h0;
    pix();
    checks++; if (sys_idx_out !== 6'h30) begin failures++; $display("FAIL spr_lane2 got=%h exp=30", sys_idx_out); end
    spr_pri_in = 8'h04; bg_idx_in = 4'h1;
    pix();
    checks++; if (sys_idx_out !== 6'h07) begin failures++; $display("FAIL spr_behind_bg got=%h exp=07", sys_idx_out); end
    bg_idx_in = 4'h0;
    pix();
    checks++; if (sys_idx_out !== 6'h30) begin failures++; $display("FAIL spr_behind_clear_bg got=%h exp=30", sys_idx_out); end
    bg_en_in = 1'b0; spr_en_in = 1'b0; bg_idx_in = 4'h5;
    pix();
    checks++; if (sys_idx_out !== 6'h2A) begin failures++; $display("FAIL backdrop got=%h exp=2a", sys_idx_out); end
    bg_en_in = 1'b1; spr_en_in = 1'b1; spr_pri_in = 8'h00; spr_idx_in = 32'h0;
  endtask

  task automatic test_clip();
    bg_idx_in = 4'h5; bg_ls_clip_in = 1'b1; nes_x_in = 10'd7;
    pix();
    checks++; if (sys_idx_out !== 6'h2A) begin failures++; $display("FAIL bg_clip_x7 got=%h exp=2a", sys_idx_out); end
    nes_x_in = 10'd8;
    pix();
    checks++; if (sys_idx_out !== 6'h16) begin failures++; $display("FAIL bg_clip_x8 got=%h exp=16", sys_idx_out); end
    bg_ls_clip_in = 1'b0; bg_idx_in = 4'h0; spr_idx_in = 32'h0000_3000; spr_ls_clip_in = 1'b1; nes_x_in = 10'd7;
    pix();
    checks++; if (sys_idx_out !== 6'h2A) begin failures++; $display("FAIL spr_clip_x7 got=%h exp=2a", sys_idx_out); end
    nes_x_in = 10'd8;
    pix();
    checks++; if (sys_idx_out !== 6'h00) begin failures++; $display("FAIL spr_clip_x8 got=%h exp=00", sys_idx_out); end
    spr_ls_clip_in = 1'b0; spr_idx_in = 32'h0;
  endtask

  task automatic test_hit();
    bg_idx_in = 4'h5; spr_idx_in = 32'h1; nes_x_in = 10'd10;
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0;
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL hit_early got=%b exp=0", spr0_hit_out); end
    tick();
    checks++; if (spr0_hit_out !== 1'b1) begin failures++; $display("FAIL hit_x10 got=%b exp=1", spr0_hit_out); end
    tick();
    checks++; if (spr0_hit_out !== 1'b1) begin failures++; $display("FAIL hit_sticky got=%b exp=1", spr0_hit_out); end
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL hit_frame_clear got=%b exp=0", spr0_hit_out); end
    nes_x_in = 10'd255;
    pix();
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL hit_x255 got=%b exp=0", spr0_hit_out); end
    spr_ls_clip_in = 1'b1; nes_x_in = 10'd7;
    pix();
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL hit_clip_x7 got=%b exp=0", spr0_hit_out); end
    spr_ls_clip_in = 1'b0;
    pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0; frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL hit_clear_wins got=%b exp=0", spr0_hit_out); end
    tick();
    checks++; if (spr0_hit_out !== 1'b0) begin failures++; $display("FAIL hit_killed got=%b exp=0", spr0_hit_out); end
    spr_idx_in = 32'h0;
  endtask

  task automatic test_grey();
    cpu_write(5'h06, 6'h2D);
    bg_idx_in = 4'h6; greyscale_in = 1'b1; emph_in = 3'b101; nes_x_in = 10'd50;
    pix();
    checks++; if (sys_idx_out !== 6'h20) begin failures++; $display("FAIL grey got=%h exp=20", sys_idx_out); end
    checks++; if (emph_out !== 3'b101) begin failures++; $display("FAIL emph got=%b exp=101", emph_out); end
    greyscale_in = 1'b0; emph_in = 3'b000;
  endtask

  task automatic test_back_to_back();
    bg_idx_in = 4'h5; pix_pulse_in = 1'b1;
    tick();
    bg_idx_in = 4'h6; emph_in = 3'b010;
    tick();
    pix_pulse_in = 1'b0; emph_in = 3'b000;
    checks++; if (pix_valid_out !== 1'b1 || sys_idx_out !== 6'h16) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/16", pix_valid_out, sys_idx_out); end
    tick();
    checks++; if (pix_valid_out !== 1'b1 || sys_idx_out !== 6'h2D || emph_out !== 3'b010) begin failures++; $display("FAIL b2b_second got=%b/%h/%b exp=1/2d/010", pix_valid_out, sys_idx_out, emph_out); end
    tick();
    checks++; if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", pix_valid_out); end
  endtask

  task automatic test_collision();
    bg_idx_in = 4'h5; pix_pulse_in = 1'b1;
    tick();
    pix_pulse_in = 1'b0; pram_a_in = 5'h05; pram_d_in = 6'h3F; pram_wr_in = 1'b1;
    tick();
    pram_wr_in = 1'b0;
    checks++; if (sys_idx_out !== 6'h16) begin failures++; $display("FAIL collide_old got=%h exp=16", sys_idx_out); end
    tick();
    checks++; if (pram_d_out !== 6'h3F) begin failures++; $display("FAIL read_after_write got=%h exp=3f", pram_d_out); end
    pix();
    checks++; if (sys_idx_out !== 6'h3F) begin failures++; $display("FAIL collide_new got=%h exp=3f", sys_idx_out); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] v;
    pram_a_in = 5'h00; emph_in = 3'b111;
    bg_idx_in = 4'h5; spr_idx_in = 32'h1; nes_x_in = 10'd20;
    pix();
    pix_pulse_in = 1'b1;
    tick();
    #3;
    rst_in = 1'b0;
    #1;
    pix_pulse_in = 1'b0;
    checks++; if (sys_idx_out !== 6'h00 || emph_out !== 3'h0 || pix_valid_out !== 1'b0) begin failures++; $display("FAIL midrst_out got=%h/%h/%b exp=00/0/0", sys_idx_out, emph_out, pix_valid_out); end
    checks++; if (spr0_hit_out !== 1'b0 || pram_d_out !== 6'h00) begin failures++; $display("FAIL midrst_hit_pram got=%b/%h exp=0/00", spr0_hit_out, pram_d_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    emph_in = 3'b000; spr_idx_in = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pix_valid_out !== 1'b0) begin failures++; $display("FAIL midrst_no_valid cyc=%0d got=%b exp=0", i, pix_valid_out); end
    end
    cpu_read(5'h05, v);
    checks++; if (v !== 6'h00) begin failures++; $display("FAIL midrst_pal05 got=%h exp=00", v); end
    cpu_read(5'h10, v);
    checks++; if (v !== 6'h00) begin failures++; $display("FAIL midrst_pal10 got=%h exp=00", v); end
  endtask

  initial begin
    rst_in = 1'b0; pix_pulse_in = 1'b0; nes_x_in = 10'd0; frame_start_in = 1'b0;
    bg_en_in = 1'b1; spr_en_in = 1'b1; bg_ls_clip_in = 1'b0; spr_ls_clip_in = 1'b0;
    greyscale_in = 1'b0; emph_in = 3'b000; bg_idx_in = 4'h0; spr_idx_in = 32'h0;
    spr_pri_in = 8'h00; pram_a_in = 5'h00; pram_d_in = 6'h00; pram_wr_in = 1'b0;
    test_reset();
    test_palette();
    test_bg();
    test_sprite();
    test_clip();
    test_hit();
    test_grey();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
